// File: rtl/prog_rom_loader_if.sv
// Byte-stream input and program-memory write port of the ROM loader.
//   in_data / in_valid / in_ready : host byte link (transfer = in_valid & in_ready)
//   prog_we / prog_waddr / prog_wdata : program memory write port
//   busy / done / err : frame status (done/err are one-cycle pulses)
// master = host side (drives the byte stream), slave = the loader.
interface prog_rom_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_waddr;
    logic [17:0]       prog_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output in_data, in_valid,
        input  in_ready, prog_we, prog_waddr, prog_wdata, busy, done, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, prog_we, prog_waddr, prog_wdata, busy, done, err
    );
endinterface

// File: rtl/prog_rom_loader.sv
// Program ROM loader: parses a framed byte stream and writes 18-bit
// instructions into program memory.
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, N x (B0,B1,B2), CSUM.
// Ports:
//   i_prog_clk : clock, all logic on rising edge
//   i_rst_n    : asynchronous active-low reset
//   bus        : prog_rom_loader_if.slave (byte link, write port, status)
//
// state  | meaning
// S_IDLE | waiting for SYNC, other bytes discarded
// S_AHI  | expecting address high bits
// S_ALO  | expecting address low byte
// S_CHI  | expecting count high bits
// S_CLO  | expecting count low byte, count validated here
// S_D0   | expecting word byte 0 (bits 17:16)
// S_D1   | expecting word byte 1 (bits 15:8)
// S_D2   | expecting word byte 2 (bits 7:0)
// S_WR   | single-cycle memory write, no byte accepted
// S_CSUM | expecting checksum byte
module prog_rom_loader #(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               i_prog_clk,
    input  logic               i_rst_n,
    prog_rom_loader_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_AHI, S_ALO, S_CHI, S_CLO,
        S_D0, S_D1, S_D2, S_WR, S_CSUM
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_ahi;
    logic [2:0]        r_cnt_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [10:0]       r_words_left;
    logic [17:0]       r_word;
    logic [7:0]        r_csum;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic [10:0]       w_cnt;
    logic              w_cnt_ok;
    logic              w_csum_ok;

    assign w_xfer    = bus.in_valid & bus.in_ready;
    assign w_cnt     = {r_cnt_hi, bus.in_data};
    assign w_cnt_ok  = (w_cnt != 11'd0) && (w_cnt <= 11'd1024);
    assign w_csum_ok = (r_csum == bus.in_data);

    // in_ready is gated by reset directly so it drops while reset is held.
    assign bus.in_ready   = i_rst_n && (r_state != S_WR);
    assign bus.prog_we    = (r_state == S_WR);
    assign bus.prog_waddr = r_addr;
    assign bus.prog_wdata = r_word;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.err        = r_err;

    always_ff @(posedge i_prog_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_xfer && bus.in_data == SYNC_BYTE) w_next = S_AHI;
            S_AHI:  if (w_xfer) w_next = S_ALO;
            S_ALO:  if (w_xfer) w_next = S_CHI;
            S_CHI:  if (w_xfer) w_next = S_CLO;
            S_CLO:  if (w_xfer) w_next = w_cnt_ok ? S_D0 : S_IDLE;
            S_D0:   if (w_xfer) w_next = S_D1;
            S_D1:   if (w_xfer) w_next = S_D2;
            S_D2:   if (w_xfer) w_next = S_WR;
            S_WR:   w_next = (r_words_left == 11'd1) ? S_CSUM : S_D0;
            S_CSUM: if (w_xfer) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_prog_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ahi        <= '0;
            r_cnt_hi     <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_xfer && bus.in_data == SYNC_BYTE) r_csum <= '0;
                S_AHI:  if (w_xfer) r_ahi <= bus.in_data[1:0];
                S_ALO:  if (w_xfer) r_addr <= ADDR_W'({r_ahi, bus.in_data});
                S_CHI:  if (w_xfer) r_cnt_hi <= bus.in_data[2:0];
                S_CLO: begin
                    if (w_xfer) begin
                        r_words_left <= w_cnt;
                        if (!w_cnt_ok) r_err <= 1'b1;
                    end
                end
                S_D0: begin
                    if (w_xfer) begin
                        r_word[17:16] <= bus.in_data[1:0];
                        r_csum        <= r_csum + bus.in_data;
                    end
                end
                S_D1: begin
                    if (w_xfer) begin
                        r_word[15:8] <= bus.in_data;
                        r_csum       <= r_csum + bus.in_data;
                    end
                end
                S_D2: begin
                    if (w_xfer) begin
                        r_word[7:0] <= bus.in_data;
                        r_csum      <= r_csum + bus.in_data;
                    end
                end
                S_WR: begin
                    // Address wraps naturally at 2^ADDR_W.
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_words_left <= r_words_left - 11'd1;
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        if (w_csum_ok) r_done <= 1'b1;
                        else           r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_rom_loader.sv
module tb_prog_rom_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_rom_loader_if #(.ADDR_W(10)) bus ();

    prog_rom_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
        .i_prog_clk (clk),
        .i_rst_n    (rst_n),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [27:0] exp_wr[$];   // {addr, data}
    int          exp_ev[$];   // 1 = DONE, 2 = ERR
    logic [17:0] words[$];
    bit          rand_hi = 1'b0;
    int          gap_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a write or a pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.prog_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", bus.prog_waddr, bus.prog_wdata);
                end else begin
                    logic [27:0] e;
                    e = exp_wr.pop_front();
                    check("write_addr_data", {bus.prog_waddr, bus.prog_wdata}, {4'd0, e});
                end
            end
            if (bus.done || bus.err) begin
                check("done_err_exclusive", {31'd0, bus.done & bus.err}, 32'd0);
                if (exp_ev.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pulse actual=done%0b/err%0b required=none", bus.done, bus.err);
                end else begin
                    int ev;
                    ev = exp_ev.pop_front();
                    check("frame_result", {30'd0, bus.done, bus.err}, (ev == 1) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int idle;
        int guard;
        idle = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (idle) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_wr.size() != 0 || exp_ev.size() != 0) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp_wr.size(), exp_ev.size());
            exp_wr.delete();
            exp_ev.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(18'($urandom));
    endtask

    // Reference model: expected writes and result derived from the frame contents.
    task automatic run_frame(input logic [9:0] addr, input logic [10:0] n, input bit bad_csum);
        logic [7:0] hr;
        logic [7:0] sum;
        logic [7:0] b0;
        logic [17:0] w;
        hr = rand_hi ? 8'($urandom) : 8'd0;
        send_byte(8'hA5);
        check("busy_after_sync", {31'd0, bus.busy}, 32'd1);
        send_byte({hr[5:0], addr[9:8]});
        send_byte(addr[7:0]);
        hr = rand_hi ? 8'($urandom) : 8'd0;
        send_byte({hr[4:0], n[10:8]});
        if (n == 0 || n > 11'd1024) begin
            exp_ev.push_back(2);
            send_byte(n[7:0]);
            check("busy_after_bad_cnt", {31'd0, bus.busy}, 32'd0);
        end else begin
            send_byte(n[7:0]);
            sum = 8'd0;
            for (int i = 0; i < int'(n); i++) begin
                w  = words[i];
                hr = rand_hi ? 8'($urandom) : 8'd0;
                b0 = {hr[5:0], w[17:16]};
                exp_wr.push_back({10'(int'(addr) + i), w});
                sum = sum + b0 + w[15:8] + w[7:0];
                send_byte(b0);
                send_byte(w[15:8]);
                send_byte(w[7:0]);
                check("we_latency", {31'd0, bus.prog_we}, 32'd1);
            end
            exp_ev.push_back(bad_csum ? 2 : 1);
            send_byte(bad_csum ? sum + 8'd1 : sum);
            check("busy_at_end", {31'd0, bus.busy}, 32'd0);
        end
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, bus.prog_we},  32'd0);
        check({tag, "_waddr"}, {22'd0, bus.prog_waddr}, 32'd0);
        check({tag, "_wdata"}, {14'd0, bus.prog_wdata}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"},  {31'd0, bus.done}, 32'd0);
        check({tag, "_err"},   {31'd0, bus.err},  32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Reset state
        #12;
        check_reset_outputs("rst0");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst0_release_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst0_release_busy",  {31'd0, bus.busy}, 32'd0);

        // Single word, exact bytes A5,00,40,00,01,03,12,34,49
        words.delete();
        words.push_back(18'h31234);
        run_frame(10'h040, 11'd1, 1'b0);

        // Burst of 8 with random valid gaps
        rand_hi = 1'b1;
        gap_max = 3;
        fill_words(8);
        run_frame(10'h040, 11'd8, 1'b0);

        // Address wrap
        fill_words(2);
        run_frame(10'h3FF, 11'd2, 1'b0);

        // Bad checksum, N=0, N=1025
        fill_words(3);
        run_frame(10'h123, 11'd3, 1'b1);
        run_frame(10'h100, 11'd0, 1'b0);
        run_frame(10'h100, 11'd1025, 1'b0);

        // Garbage before SYNC, then a good frame
        send_byte(8'h00);
        send_byte(8'hFF);
        fill_words(1);
        run_frame(10'h200, 11'd1, 1'b0);

        // Reset while in D1: partial frame sent by hand, no expectations pushed
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_release_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mid_release_busy",  {31'd0, bus.busy}, 32'd0);
        fill_words(2);
        run_frame(10'h010, 11'd2, 1'b0);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            logic [9:0]  a;
            logic [10:0] n;
            a = 10'($urandom);
            n = 11'($urandom_range(1, 5));
            fill_words(int'(n));
            run_frame(a, n, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
